// File: rtl/kuz_pkg.sv
// Shared types, constants and GF(2^8) helper for the Kuznechik L-transform sequencer.
// Optional inverse mode is enabled by defining KUZ_L_INV_EN.
package kuz_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Low byte of the field polynomial x^8+x^7+x^6+x+1.
    localparam logic [7:0] GF_POLY = 8'hC3;

    localparam logic [7:0] L_COEF [16] = '{
        8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,   8'd251,
        8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148, 8'd1
    };

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
        end
        return acc;
    endfunction

endpackage

// File: rtl/kuz_r_step.sv
// One combinational Kuznechik R step (byte shift plus linear feedback byte).
// With KUZ_L_INV_EN defined, an inv select chooses R^-1 instead.
module kuz_r_step
    import kuz_pkg::*;
(
    input  block_t a,
`ifdef KUZ_L_INV_EN
    input  logic   inv,
`endif
    output block_t y
);

    logic [7:0] fwd_fb;
    block_t     fwd;

    always_comb begin
        fwd_fb = 8'h00;
        for (int i = 0; i < 16; i++) begin
            fwd_fb = fwd_fb ^ gmul(L_COEF[i], a[8*i +: 8]);
        end
        fwd = {a[119:0], fwd_fb};
    end

`ifdef KUZ_L_INV_EN
    logic [7:0] inv_fb;
    block_t     bwd;

    // The dropped top byte is recovered from byte 0 and the shifted-down bytes.
    always_comb begin
        inv_fb = a[7:0];
        for (int i = 0; i < 15; i++) begin
            inv_fb = inv_fb ^ gmul(L_COEF[i], a[8*(i+1) +: 8]);
        end
        bwd = {inv_fb, a[127:8]};
    end

    assign y = inv ? bwd : fwd;
`else
    assign y = fwd;
`endif

endmodule

// File: rtl/kuz_l_seq.sv
// Iterative Kuznechik L sequencer: ROUNDS R steps per block, one per clock.
// Defining KUZ_L_INV_EN adds the in_inv port and an inverse-mode flop.
module kuz_l_seq
    import kuz_pkg::*;
#(
    parameter int ROUNDS = 16,
    parameter int CNT_W  = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef KUZ_L_INV_EN
    input  logic         in_inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    state_t           state;
    block_t           sreg;
    block_t           step_out;
    logic [CNT_W-1:0] cnt;
    logic             last_step;

    assign last_step = (cnt == CNT_W'(ROUNDS - 1));

`ifdef KUZ_L_INV_EN
    logic mode_inv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_inv <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            mode_inv <= in_inv;
        end
    end

    kuz_r_step u_step (
        .a   (sreg),
        .inv (mode_inv),
        .y   (step_out)
    );
`else
    kuz_r_step u_step (
        .a (sreg),
        .y (step_out)
    );
`endif

    // State register is cleared too so out_data reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg  <= in_data;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sreg <= step_out;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_step) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);
    assign out_data  = sreg;

endmodule

// File: tb/tb_kuz_l_seq.sv
// Self-checking bench for kuz_l_seq: block-level reference model plus directed literal vectors.
module tb_kuz_l_seq;

`ifdef KUZ_L_INV_EN
    localparam bit INV_ON = 1'b1;
`else
    localparam bit INV_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    // ROUNDS=16 instance
    logic         iv = 1'b0, ir, ov, ordy = 1'b0, bsy, inv = 1'b0;
    logic [127:0] id = '0, od;
    // ROUNDS=1 instance
    logic         iv1 = 1'b0, ir1, ov1, ordy1 = 1'b0, bsy1, inv1 = 1'b0;
    logic [127:0] id1 = '0, od1;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    kuz_l_seq #(.ROUNDS(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_data(id),
`ifdef KUZ_L_INV_EN
        .in_inv(inv),
`endif
        .out_valid(ov), .out_ready(ordy), .out_data(od), .busy(bsy)
    );

    kuz_l_seq #(.ROUNDS(1), .CNT_W(5)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
`ifdef KUZ_L_INV_EN
        .in_inv(inv1),
`endif
        .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .busy(bsy1)
    );

    // ---------------- reference model ----------------
    localparam int CF [16] = '{148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1};

    // Carry-less product followed by long division by 0x1C3.
    function automatic logic [7:0] gf(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h01C3 << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] r_ref(input logic [127:0] a, input logic inv_b);
        logic [7:0] by [16];
        logic [7:0] t;
        for (int i = 0; i < 16; i++) by[i] = a[8*i +: 8];
        if (!inv_b) begin
            t = 8'h00;
            for (int i = 0; i < 16; i++) t = t ^ gf(8'(CF[i]), by[i]);
            return {a[119:0], t};
        end
        t = by[0];
        for (int i = 0; i < 15; i++) t = t ^ gf(8'(CF[i]), by[i+1]);
        return {t, a[127:8]};
    endfunction

    function automatic logic [127:0] l_ref(input logic [127:0] a, input int n, input logic inv_b);
        logic [127:0] s;
        s = a;
        for (int k = 0; k < n; k++) s = r_ref(s, inv_b);
        return s;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Cycle-level expectation for the ROUNDS=16 instance: 0 idle, 1 run, 2 done.
    int           mstate = 0;
    int           msteps = 0;
    logic [127:0] mexp   = '0;

    always @(negedge clk) begin
        if (rst) begin
            mstate = 0;
            chk("rst_out_valid", 128'(ov), 128'(0));
            chk("rst_busy", 128'(bsy), 128'(0));
            chk("rst_out_data", od, 128'(0));
        end else begin
            chk("in_ready", 128'(ir), 128'(mstate == 0));
            chk("busy", 128'(bsy), 128'(mstate == 1));
            chk("out_valid", 128'(ov), 128'(mstate == 2));
            if (mstate == 2) chk("out_data", od, mexp);
            case (mstate)
                0: if (iv) begin
                    mstate = 1;
                    msteps = 0;
                    mexp   = l_ref(id, 16, INV_ON && inv);
                end
                1: begin
                    msteps++;
                    if (msteps == 16) mstate = 2;
                end
                default: if (ordy) mstate = 0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run1(input string nm, input logic [127:0] d, input logic inv_b, input logic [127:0] exp);
        int n;
        chk({nm, "_in_ready"}, 128'(ir1), 128'(1));
        iv1 = 1'b1; id1 = d; inv1 = inv_b;
        tick();
        iv1 = 1'b0; id1 = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        while (!ov1 && n < 8) begin
            tick();
            n++;
        end
        chk({nm, "_latency"}, 128'(n), 128'(1));
        chk({nm, "_data"}, od1, exp);
        ordy1 = 1'b1;
        tick();
        ordy1 = 1'b0;
        chk({nm, "_released"}, 128'(ov1), 128'(0));
    endtask

    task automatic send16(input logic [127:0] d, input logic inv_b, output logic [127:0] res);
        int n;
        iv = 1'b1; id = d; inv = inv_b; ordy = 1'b0;
        tick();
        iv = 1'b0; id = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        while (!ov && n < 40) begin
            tick();
            n++;
        end
        chk("send_latency", 128'(n), 128'(16));
        res = od;
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
    endtask

    initial begin
        logic [127:0] r, r2, held;
        int n;

        // Hand-computed literals pin the model itself.
        chk("model_r_a", r_ref(128'hA041ABB1A445B706C6D90D0DB0F33A7A, 1'b0),
            128'h41ABB1A445B706C6D90D0DB0F33A7A0D);
        chk("model_r_b", r_ref(128'h6A5784285CF6F3BDF82A0715729A8AA0, 1'b0),
            128'h5784285CF6F3BDF82A0715729A8AA00F);
        chk("model_rinv_b", r_ref(128'h5784285CF6F3BDF82A0715729A8AA00F, 1'b1),
            128'h6A5784285CF6F3BDF82A0715729A8AA0);

        tick(); tick();
        rst = 1'b0;
        tick();

        run1("r1_a", 128'hA041ABB1A445B706C6D90D0DB0F33A7A, 1'b0, 128'h41ABB1A445B706C6D90D0DB0F33A7A0D);
        run1("r1_b", 128'h6A5784285CF6F3BDF82A0715729A8AA0, 1'b0, 128'h5784285CF6F3BDF82A0715729A8AA00F);
        if (INV_ON)
            run1("r1_inv", 128'h5784285CF6F3BDF82A0715729A8AA00F, 1'b1, 128'h6A5784285CF6F3BDF82A0715729A8AA0);

        // Zero block: output zero, busy for exactly 16 cycles.
        iv = 1'b1; id = '0; inv = 1'b0;
        tick();
        iv = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && !ov; c++) begin
            if (bsy) n++;
            chk("zero_in_ready_low", 128'(ir), 128'(0));
            tick();
        end
        chk("zero_busy_cycles", 128'(n), 128'(16));
        chk("zero_out", od, 128'(0));
        ordy = 1'b1;
        tick();
        ordy = 1'b0;

        // Backpressure in DONE with stray in_valid pulses.
        iv = 1'b1; id = {$urandom, $urandom, $urandom, $urandom};
        tick();
        iv = 1'b0;
        n = 0;
        while (!ov && n < 40) begin
            tick();
            n++;
        end
        held = od;
        for (int c = 0; c < 10; c++) begin
            iv = c[0];
            id = {$urandom, $urandom, $urandom, $urandom};
            tick();
            chk("bp_valid_held", 128'(ov), 128'(1));
            chk("bp_data_held", od, held);
        end
        iv = 1'b0;
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        chk("bp_single_transfer", 128'(ov), 128'(0));

        // Asynchronous reset once seven steps have been applied.
        iv = 1'b1; id = {$urandom, $urandom, $urandom, $urandom};
        tick();
        iv = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(ov), 128'(0));
        chk("midrst_busy", 128'(bsy), 128'(0));
        chk("midrst_out_data", od, 128'(0));
        tick();
        rst = 1'b0;
        tick();
        send16(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, r);
        chk("after_rst_block", r, l_ref(128'h0123456789ABCDEF_FEDCBA9876543210, 16, 1'b0));

        if (INV_ON) begin
            send16(128'hF568709391A9BE8AECE905C377586FAE, 1'b0, r);
            chk("fwd16", r, l_ref(128'hF568709391A9BE8AECE905C377586FAE, 16, 1'b0));
            send16(r, 1'b1, r2);
            chk("inv16_roundtrip", r2, 128'hF568709391A9BE8AECE905C377586FAE);
        end

        // Randomized traffic; the negedge model checks every cycle.
        for (int c = 0; c < 6000; c++) begin
            iv   = ($urandom_range(0, 2) != 0);
            id   = {$urandom, $urandom, $urandom, $urandom};
            inv  = INV_ON ? 1'($urandom_range(0, 1)) : 1'b0;
            ordy = ($urandom_range(0, 3) != 0);
            tick();
        end
        iv = 1'b0;
        ordy = 1'b1;
        for (int c = 0; c < 30; c++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
        $fatal(1);
    end

endmodule
